// File: rtl/threat_countdown_pkg.sv
// Purpose : shared types and helpers for the threat countdown block.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: ts_state_t state enum, TS_W state width, popcount() helper.
package threat_pkg;

  localparam int TS_W = 2;

  typedef enum logic [TS_W-1:0] {
    TS_DISARMED = 2'd0,
    TS_WATCH    = 2'd1,
    TS_COUNT    = 2'd2,
    TS_DONE     = 2'd3
  } ts_state_t;

  // Sized for the widest supported channel count (16).
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/threat_countdown_debounce.sv
// Purpose : one alarm channel: 2-flop synchroniser, tick-based debounce counter, clean level.
// Latency : 2 clk sync, then DEB_TICKS ticks of a stable changed level before clean follows.
// Backpressure: none; free-running on clk, advances only on tick.
// Ports   : clk, reset (sync, active-low), tick, raw (async switch), clean (debounced level).
module threat_debounce #(
  parameter int DEB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic clean
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle where the level agrees with clean restarts the run, so a
      // glitch must persist across DEB_TICKS consecutive ticks to get through.
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == DEB_LAST) begin
          clean <= ~clean;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/threat_countdown.sv
// Purpose : K-of-N debounced alarm vote driving a thermometer LED bar countdown; done when full.
// Latency : clean->vote 1 clk, vote->state 1 clk; one bar step per STEP_TICKS ticks in COUNT.
// Backpressure: none; tick is a single-cycle enable, outputs are plain levels.
// Ports   : clk, reset (sync, active-low), tick, arm, sw[N_CH] -> clean[N_CH], state[2], led[BAR_W], done.
// Option  : THREAT_COUNTDOWN_BLINK_EN adds a blinking bar in COUNT and a steady full bar in DONE.
module threat_countdown
  import threat_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int K_MIN       = 2,
  parameter int DEB_TICKS   = 3,
  parameter int STEP_TICKS  = 100,
  parameter int BAR_W       = 8,
  parameter int BLINK_TICKS = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              arm,
  input  logic [N_CH-1:0]   sw,
  output logic [N_CH-1:0]   clean,
  output logic [TS_W-1:0]   state,
  output logic [BAR_W-1:0]  led,
  output logic              done
);

  if (N_CH < 1 || N_CH > 16)             $error("N_CH out of range");
  if (K_MIN < 1 || K_MIN > N_CH)         $error("K_MIN out of range");
  if (DEB_TICKS < 1 || DEB_TICKS > 15)   $error("DEB_TICKS out of range");
  if (STEP_TICKS < 1 || STEP_TICKS > 1023) $error("STEP_TICKS out of range");
  if (BAR_W < 2 || BAR_W > 32)           $error("BAR_W out of range");
  if (BLINK_TICKS < 1 || BLINK_TICKS > 1023) $error("BLINK_TICKS out of range");

  localparam logic [9:0] STEP_LAST = 10'(STEP_TICKS - 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_deb
    threat_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (sw[g]),
      .clean(clean[g])
    );
  end

  logic vote;
  always_ff @(posedge clk) begin
    if (!reset) vote <= 1'b0;
    else        vote <= (popcount(16'(clean)) >= 5'(K_MIN));
  end

  ts_state_t        state_q, state_n;
  logic [BAR_W-1:0] bar_q, bar_n;
  logic [9:0]       step_q, step_n;

  always_comb begin
    state_n = state_q;
    bar_n   = bar_q;
    step_n  = step_q;
    if (!arm) begin
      state_n = TS_DISARMED;
      bar_n   = '0;
      step_n  = '0;
    end else begin
      unique case (state_q)
        TS_DISARMED: begin
          state_n = TS_WATCH;
          bar_n   = '0;
          step_n  = '0;
        end
        TS_WATCH: begin
          bar_n  = '0;
          step_n = '0;
          if (vote) state_n = TS_COUNT;
        end
        TS_COUNT: begin
          // Vote loss wins over a coincident step tick.
          if (!vote) begin
            state_n = TS_WATCH;
            bar_n   = '0;
            step_n  = '0;
          end else if (tick) begin
            if (step_q == STEP_LAST) begin
              bar_n  = {bar_q[BAR_W-2:0], 1'b1};
              step_n = '0;
              if (&bar_n) state_n = TS_DONE;
            end else begin
              step_n = step_q + 10'd1;
            end
          end
        end
        TS_DONE: begin
          state_n = TS_DONE;
        end
        default: begin
          state_n = TS_DISARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= TS_DISARMED;
      bar_q   <= '0;
      step_q  <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      bar_q   <= bar_n;
      step_q  <= step_n;
      // Taken from the next state so done rises and clears with state itself.
      done    <= (state_n == TS_DONE);
    end
  end

  assign state = state_q;

`ifdef THREAT_COUNTDOWN_BLINK_EN
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_TICKS - 1);

  logic       phase_q;
  logic [9:0] blink_q;

  // Blink timing only runs while staying in COUNT; any other cycle re-primes
  // it so every entry to COUNT starts with the bar visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= 1'b1;
      blink_q <= '0;
    end else if (state_q == TS_COUNT && state_n == TS_COUNT) begin
      if (tick) begin
        if (blink_q == BLINK_LAST) begin
          phase_q <= ~phase_q;
          blink_q <= '0;
        end else begin
          blink_q <= blink_q + 10'd1;
        end
      end
    end else begin
      phase_q <= 1'b1;
      blink_q <= '0;
    end
  end

  always_comb begin
    led = '0;
    if (state_q == TS_COUNT)     led = bar_q & {BAR_W{phase_q}};
    else if (state_q == TS_DONE) led = '1;
  end
`else
  assign led = bar_q;
`endif

endmodule

// File: tb/tb_threat_countdown.sv
module tb_threat_countdown;

  localparam int N_CH  = 3;
  localparam int K_MIN = 2;
  localparam int DEB   = 3;
  localparam int STEP  = 4;
  localparam int BAR_W = 8;
  localparam int BLINK = 2;

  localparam int MD_OFF   = 0;
  localparam int MD_WATCH = 1;
  localparam int MD_COUNT = 2;
  localparam int MD_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       arm;
  logic [2:0] sw;
  logic [2:0] clean;
  logic [1:0] state;
  logic [7:0] led;
  logic       done;

  threat_countdown #(
    .N_CH(N_CH), .K_MIN(K_MIN), .DEB_TICKS(DEB), .STEP_TICKS(STEP),
    .BAR_W(BAR_W), .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .arm(arm), .sw(sw),
    .clean(clean), .state(state), .led(led), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: raw history, per-channel run lengths, a mode number
  // and the number of ticks spent counting; the bar is derived arithmetically.
  logic [2:0] m_s1 = '0, m_s2 = '0, m_clean = '0;
  int         m_run [3];
  logic       m_vote = 1'b0;
  int         m_mode = MD_OFF;
  int         m_ticks = 0;
  logic       saw_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] exp_led();
    int         lit;
    logic [7:0] bar;
    lit = m_ticks / STEP;
    if (lit > BAR_W) lit = BAR_W;
    bar = 8'((32'h1 << lit) - 1);
    if (m_mode == MD_DONE)  return 8'hFF;
    if (m_mode != MD_COUNT) return 8'h00;
`ifdef THREAT_COUNTDOWN_BLINK_EN
    if (((m_ticks / BLINK) % 2) == 1) return 8'h00;
`endif
    return bar;
  endfunction

  task automatic model_edge(input logic [2:0] s, input logic a, input logic r, input logic tk);
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_vote = 1'b0;
      m_mode = MD_OFF; m_ticks = 0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else begin
      if (!a) begin
        m_mode = MD_OFF; m_ticks = 0;
      end else begin
        case (m_mode)
          MD_OFF:   m_mode = MD_WATCH;
          MD_WATCH: if (m_vote) begin m_mode = MD_COUNT; m_ticks = 0; end
          MD_COUNT: begin
            if (!m_vote) begin
              m_mode = MD_WATCH; m_ticks = 0;
            end else if (tk) begin
              m_ticks++;
              if (m_ticks == BAR_W * STEP) m_mode = MD_DONE;
            end
          end
          default: ;
        endcase
      end
      m_vote = ($countones(m_clean) >= K_MIN);
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] == m_clean[c]) m_run[c] = 0;
        else if (tk) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_clean[c] = ~m_clean[c];
            m_run[c]   = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = s;
    end
  endtask

  task automatic cycle(input logic [2:0] s, input logic a, input logic r);
    logic tk;
    @(negedge clk);
    tk = ((cyc % 4) == 0);
    cyc++;
    sw = s; arm = a; reset = r; tick = tk;
    @(posedge clk);
    model_edge(s, a, r, tk);
    #1;
    chk("clean", 32'(clean), 32'(m_clean));
    chk("state", 32'(state), 32'(m_mode));
    chk("led",   32'(led),   32'(exp_led()));
    chk("done",  32'(done),  32'(m_mode == MD_DONE));
    if (done) saw_done = 1'b1;
  endtask

  logic [2:0] pat_tbl [8] = '{3'b011, 3'b111, 3'b110, 3'b101, 3'b001, 3'b000, 3'b011, 3'b111};

  initial begin
    int k;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
    reset = 1'b0; arm = 1'b1; sw = 3'b111; tick = 1'b0;

    // Reset held with everything active.
    repeat (5) cycle(3'b111, 1'b1, 1'b0);

    // Short glitch (2 ticks) must not pass; a 3-tick hold must.
    repeat (8)  cycle(3'b001, 1'b0, 1'b1);
    repeat (20) cycle(3'b000, 1'b0, 1'b1);
    repeat (16) cycle(3'b001, 1'b0, 1'b1);
    chk("deb_hold_clean0", 32'(clean[0]), 32'd1);
    repeat (16) cycle(3'b000, 1'b0, 1'b1);

    // Full fill to DONE, then disarm.
    repeat (200) cycle(3'b011, 1'b1, 1'b1);
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_led",  32'(led),  32'hFF);
    cycle(3'b011, 1'b0, 1'b1);
    chk("disarm_state", 32'(state), 32'd0);
    chk("disarm_done",  32'(done),  32'd0);

    // Vote loss at bar 07, then restart.
    k = 0;
    while (exp_led() != 8'h07 && k < 400) begin
      cycle(3'b011, 1'b1, 1'b1);
      k++;
    end
    chk("reach_bar07", 32'(led), 32'h07);
    repeat (40) cycle(3'b001, 1'b1, 1'b1);
    chk("loss_state", 32'(state), 32'd1);
    chk("loss_led",   32'(led),   32'd0);
    repeat (200) cycle(3'b011, 1'b1, 1'b1);

    // Reset in the middle of counting.
    cycle(3'b011, 1'b0, 1'b1);
    repeat (60) cycle(3'b011, 1'b1, 1'b1);
    cycle(3'b011, 1'b1, 1'b0);
    chk("midreset_led", 32'(led), 32'd0);

    // Randomised segments.
    for (int seg = 0; seg < 50; seg++) begin
      logic [2:0] p;
      logic       a, r;
      int         len;
      p   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : pat_tbl[$urandom_range(0, 7)];
      a   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 14) != 0);
      len = r ? $urandom_range(1, 150) : $urandom_range(1, 3);
      repeat (len) cycle(p, a, r);
    end

    chk("saw_done", 32'(saw_done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
